// File: rtl/round_permutation_engine.sv
// Iterative per-lane rotate engine for the BORON round: rotl (encrypt) or rotr (decrypt), applied N times.
// Define ROUND_PERM_BACK2BACK_EN to accept the next block in the same edge as the output handshake.
module round_permutation_engine #(
    parameter int unsigned        LANES  = 4,
    parameter int unsigned        LANE_W = 16,
    parameter logic [8*LANES-1:0] ROT    = 32'h09070401,
    parameter int unsigned        CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic                      in_mode,
    input  logic [CNT_W-1:0]          in_reps,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic                      busy
);

    localparam int unsigned DATA_W = LANES * LANE_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mode;
    logic [DATA_W-1:0]   w_perm;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;
    logic                w_load;
    logic                w_step;

    generate
        if (LANES < 1 || LANE_W < 2) begin : g_bad_geom
            $error("round_permutation_engine: need LANES >= 1 and LANE_W >= 2");
        end
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rot_chk
            if (32'(ROT[gi*8 +: 8]) >= LANE_W) begin : g_bad_rot
                $error("round_permutation_engine: ROT byte %0d must be below LANE_W", gi);
            end
        end
    endgenerate

    // Rotating the doubled word keeps the amount-0 case a plain identity with no special casing.
    function automatic logic [LANE_W-1:0] rot_lane(input logic [LANE_W-1:0] v,
                                                   input logic [7:0]        amt,
                                                   input logic              right);
        logic [2*LANE_W-1:0] dbl;
        int unsigned         sh;
        dbl = {v, v};
        sh  = right ? 32'(amt) : LANE_W - 32'(amt);
        dbl = dbl >> sh;
        return dbl[LANE_W-1:0];
    endfunction

    always_comb begin
        w_perm = '0;
        for (int i = 0; i < LANES; i++) begin
            w_perm[i*LANE_W +: LANE_W] = rot_lane(r_data[i*LANE_W +: LANE_W], ROT[i*8 +: 8], r_mode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~rst;
                if (in_valid && w_in_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = (in_reps == '0) ? S_HOLD : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
`ifdef ROUND_PERM_BACK2BACK_EN
                w_in_ready  = out_ready & ~rst;
`endif
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    // Only reachable with back-to-back enabled: a new block replaces the one leaving.
                    if (in_valid && w_in_ready) begin
                        w_load      = 1'b1;
                        w_state_nxt = (in_reps == '0) ? S_HOLD : S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_load) begin
            r_data <= in_data;
            r_cnt  <= in_reps;
            r_mode <= in_mode;
        end else if (w_step) begin
            r_data <= w_perm;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign out_data  = r_data;

endmodule
